// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle sequencing controller for the MIPS datapath.
// Steps each instruction through IF, ID, EX, MEM and WB. Every control output
// is a combinational function of the current state and the IR opcode/funct,
// plus Zero (branch EX) and mem_ready (IF/MEM).
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   Op, Funct        opcode and funct fields from IR
//   Zero             ALU zero flag (used only in EX of beq/bne)
//   mem_ready        unified memory completes the current access this cycle
//   PCWrite/IRWrite  PC and IR load strobes
//   IorD             memory address select (0=PC, 1=ALU result)
//   MemRead/MemWrite memory port requests
//   RegWrite         register-file write strobe
//   EXTOp            1=sign-extend imm16, 0=zero-extend
//   ALUSrc, AregSel  ALU operand B / A selects
//   ALUOp            ALU function code
//   NPCOp            next-PC source
//   GPRSel, WDSel    register-file destination / write-data selects
//   state            current FSM state (debug)
//   retire, illegal  completion and unsupported-encoding pulses
module mc_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       EXTOp,
  output logic       ALUSrc,
  output logic       AregSel,
  output logic [3:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [2:0] state,
  output logic       retire,
  output logic       illegal
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned ST_W  = 3;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
  localparam logic [OP_W-1:0] FN_JR   = 6'h08;
  localparam logic [OP_W-1:0] FN_JALR = 6'h09;
  localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2a;
  localparam logic [OP_W-1:0] FN_SLTU = 6'h2b;

  // ALU function codes
  localparam logic [ALU_W-1:0] ALU_NOP  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_NOR  = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_LUI  = 4'b1010;

  // Next-PC, destination and write-data selects
  localparam logic [SEL_W-1:0] NPC_PC4    = 2'b00;
  localparam logic [SEL_W-1:0] NPC_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] NPC_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] NPC_REG    = 2'b11;
  localparam logic [SEL_W-1:0] GPR_RD     = 2'b00;
  localparam logic [SEL_W-1:0] GPR_RT     = 2'b01;
  localparam logic [SEL_W-1:0] GPR_RA     = 2'b10;
  localparam logic [SEL_W-1:0] WD_ALU     = 2'b00;
  localparam logic [SEL_W-1:0] WD_MEM     = 2'b01;
  localparam logic [SEL_W-1:0] WD_PC      = 2'b10;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_e;

  typedef enum logic [4:0] {
    IN_ILLEGAL, IN_ADD, IN_ADDU, IN_SUB, IN_SUBU, IN_AND, IN_OR, IN_NOR,
    IN_SLT, IN_SLTU, IN_SLL, IN_SRL, IN_JR, IN_JALR, IN_ADDI, IN_ANDI,
    IN_ORI, IN_SLTI, IN_LUI, IN_LW, IN_SW, IN_BEQ, IN_BNE, IN_J, IN_JAL
  } instr_e;

  state_e             state_q;
  state_e             state_d;
  instr_e             instr;
  logic [ALU_W-1:0]   alu_op;
  logic               ext_sign;
  logic               alu_b_imm;
  logic               alu_a_shamt;
  logic               i_alu;

  // Full 6-bit decode; anything not listed (including near misses) is illegal.
  always_comb begin
    instr = IN_ILLEGAL;
    if (Op == OP_RTYPE) begin
      case (Funct)
        FN_ADD:  instr = IN_ADD;
        FN_ADDU: instr = IN_ADDU;
        FN_SUB:  instr = IN_SUB;
        FN_SUBU: instr = IN_SUBU;
        FN_AND:  instr = IN_AND;
        FN_OR:   instr = IN_OR;
        FN_NOR:  instr = IN_NOR;
        FN_SLT:  instr = IN_SLT;
        FN_SLTU: instr = IN_SLTU;
        FN_SLL:  instr = IN_SLL;
        FN_SRL:  instr = IN_SRL;
        FN_JR:   instr = IN_JR;
        FN_JALR: instr = IN_JALR;
        default: instr = IN_ILLEGAL;
      endcase
    end else begin
      case (Op)
        OP_ADDI: instr = IN_ADDI;
        OP_ANDI: instr = IN_ANDI;
        OP_ORI:  instr = IN_ORI;
        OP_SLTI: instr = IN_SLTI;
        OP_LUI:  instr = IN_LUI;
        OP_LW:   instr = IN_LW;
        OP_SW:   instr = IN_SW;
        OP_BEQ:  instr = IN_BEQ;
        OP_BNE:  instr = IN_BNE;
        OP_J:    instr = IN_J;
        OP_JAL:  instr = IN_JAL;
        default: instr = IN_ILLEGAL;
      endcase
    end
  end

  // Per-instruction datapath attributes used from ID onward.
  always_comb begin
    alu_op      = ALU_NOP;
    ext_sign    = 1'b0;
    alu_b_imm   = 1'b0;
    alu_a_shamt = 1'b0;
    i_alu       = 1'b0;
    case (instr)
      IN_ADD, IN_ADDU: alu_op = ALU_ADD;
      IN_SUB, IN_SUBU: alu_op = ALU_SUB;
      IN_AND:          alu_op = ALU_AND;
      IN_OR:           alu_op = ALU_OR;
      IN_NOR:          alu_op = ALU_NOR;
      IN_SLT:          alu_op = ALU_SLT;
      IN_SLTU:         alu_op = ALU_SLTU;
      IN_SLL: begin
        alu_op      = ALU_SLL;
        alu_a_shamt = 1'b1;
      end
      IN_SRL: begin
        alu_op      = ALU_SRL;
        alu_a_shamt = 1'b1;
      end
      IN_ADDI: begin
        alu_op    = ALU_ADD;
        ext_sign  = 1'b1;
        alu_b_imm = 1'b1;
        i_alu     = 1'b1;
      end
      IN_ANDI: begin
        alu_op    = ALU_AND;
        alu_b_imm = 1'b1;
        i_alu     = 1'b1;
      end
      IN_ORI: begin
        alu_op    = ALU_OR;
        alu_b_imm = 1'b1;
        i_alu     = 1'b1;
      end
      IN_SLTI: begin
        alu_op    = ALU_SLT;
        ext_sign  = 1'b1;
        alu_b_imm = 1'b1;
        i_alu     = 1'b1;
      end
      IN_LUI: begin
        alu_op    = ALU_LUI;
        alu_b_imm = 1'b1;
        i_alu     = 1'b1;
      end
      IN_LW, IN_SW: begin
        alu_op    = ALU_ADD;
        ext_sign  = 1'b1;
        alu_b_imm = 1'b1;
      end
      IN_BEQ, IN_BNE: begin
        alu_op   = ALU_SUB;
        ext_sign = 1'b1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and control outputs
  always_comb begin
    state_d  = state_q;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    AregSel  = 1'b0;
    ALUOp    = ALU_NOP;
    NPCOp    = NPC_PC4;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_IF;

      // Fetch: hold the read request until memory completes it.
      S_IF: begin
        MemRead = 1'b1;
        IorD    = 1'b0;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          NPCOp   = NPC_PC4;
          state_d = S_ID;
        end
      end

      // Decode: jumps complete here, unsupported encodings are dropped as NOPs.
      S_ID: begin
        EXTOp   = ext_sign;
        state_d = S_EX;
        case (instr)
          IN_J: begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JUMP;
            retire  = 1'b1;
            state_d = S_IF;
          end
          IN_JAL: begin
            PCWrite  = 1'b1;
            NPCOp    = NPC_JUMP;
            RegWrite = 1'b1;
            GPRSel   = GPR_RA;
            WDSel    = WD_PC;
            retire   = 1'b1;
            state_d  = S_IF;
          end
          IN_JR: begin
            PCWrite = 1'b1;
            NPCOp   = NPC_REG;
            retire  = 1'b1;
            state_d = S_IF;
          end
          IN_JALR: begin
            PCWrite  = 1'b1;
            NPCOp    = NPC_REG;
            RegWrite = 1'b1;
            GPRSel   = GPR_RA;
            WDSel    = WD_PC;
            retire   = 1'b1;
            state_d  = S_IF;
          end
          IN_ILLEGAL: begin
            illegal = 1'b1;
            state_d = S_IF;
          end
          default: ;
        endcase
      end

      // Execute: branches resolve on Zero and complete here.
      S_EX: begin
        ALUOp   = alu_op;
        ALUSrc  = alu_b_imm;
        AregSel = alu_a_shamt;
        EXTOp   = ext_sign;
        state_d = S_WB;
        if (instr == IN_BEQ || instr == IN_BNE) begin
          NPCOp   = NPC_BRANCH;
          PCWrite = (instr == IN_BEQ) ? Zero : ~Zero;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (instr == IN_LW || instr == IN_SW) begin
          state_d = S_MEM;
        end
      end

      // Data access at the ALU result address. ALUOp stays at the
      // instruction's function through MEM and WB so the ALU output is stable.
      S_MEM: begin
        IorD  = 1'b1;
        ALUOp = alu_op;
        if (instr == IN_SW) begin
          MemWrite = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_IF;
          end
        end else begin
          MemRead = 1'b1;
          if (mem_ready) state_d = S_WB;
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        ALUOp    = alu_op;
        state_d  = S_IF;
        if (instr == IN_LW) begin
          WDSel  = WD_MEM;
          GPRSel = GPR_RT;
        end else if (i_alu) begin
          WDSel  = WD_ALU;
          GPRSel = GPR_RT;
        end else begin
          WDSel  = WD_ALU;
          GPRSel = GPR_RD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign state = ST_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: checks mc_ctrl cycle by cycle against a trace model that
// expands each instruction into its expected sequence of control vectors.
`timescale 1ns/1ps
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       irw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       rw;
    logic       ext;
    logic       asrc;
    logic       asel;
    logic [3:0] aluop;
    logic [1:0] npc;
    logic [1:0] gsel;
    logic [1:0] wdsel;
    logic       ret;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic mr;
    logic z;
  } step_t;

  typedef enum logic [3:0] {
    K_ILL, K_J, K_JAL, K_JR, K_JALR, K_BEQ, K_BNE, K_LW, K_SW, K_RALU, K_IALU
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] alu;
    logic       ext;
    logic       shift;
  } info_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
  logic       EXTOp, ALUSrc, AregSel;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic [2:0] state;
  logic       retire, illegal;

  int vectors = 0;
  int miscompares = 0;
  step_t steps[$];
  ctl_t obs;

  mc_ctrl dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .EXTOp(EXTOp), .ALUSrc(ALUSrc), .AregSel(AregSel), .ALUOp(ALUOp),
    .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel), .state(state),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {state, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite,
                EXTOp, ALUSrc, AregSel, ALUOp, NPCOp, GPRSel, WDSel,
                retire, illegal};

  // Instruction table: class, ALU function, sign-extension, shift-A select.
  function automatic info_t decode(input logic [5:0] op, input logic [5:0] fn);
    info_t i;
    i.kind = K_ILL; i.alu = 4'd0; i.ext = 1'b0; i.shift = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: begin i.kind = K_RALU; i.alu = 4'd1; end
        6'h22, 6'h23: begin i.kind = K_RALU; i.alu = 4'd2; end
        6'h24: begin i.kind = K_RALU; i.alu = 4'd3; end
        6'h25: begin i.kind = K_RALU; i.alu = 4'd4; end
        6'h27: begin i.kind = K_RALU; i.alu = 4'd9; end
        6'h2a: begin i.kind = K_RALU; i.alu = 4'd5; end
        6'h2b: begin i.kind = K_RALU; i.alu = 4'd6; end
        6'h00: begin i.kind = K_RALU; i.alu = 4'd7; i.shift = 1'b1; end
        6'h02: begin i.kind = K_RALU; i.alu = 4'd8; i.shift = 1'b1; end
        6'h08: i.kind = K_JR;
        6'h09: i.kind = K_JALR;
        default: ;
      endcase
    end else begin
      case (op)
        6'h08: begin i.kind = K_IALU; i.alu = 4'd1; i.ext = 1'b1; end
        6'h0c: begin i.kind = K_IALU; i.alu = 4'd3; end
        6'h0d: begin i.kind = K_IALU; i.alu = 4'd4; end
        6'h0a: begin i.kind = K_IALU; i.alu = 4'd5; i.ext = 1'b1; end
        6'h0f: begin i.kind = K_IALU; i.alu = 4'd10; end
        6'h23: begin i.kind = K_LW; i.alu = 4'd1; i.ext = 1'b1; end
        6'h2b: begin i.kind = K_SW; i.alu = 4'd1; i.ext = 1'b1; end
        6'h04: begin i.kind = K_BEQ; i.alu = 4'd2; i.ext = 1'b1; end
        6'h05: begin i.kind = K_BNE; i.alu = 4'd2; i.ext = 1'b1; end
        6'h02: i.kind = K_J;
        6'h03: i.kind = K_JAL;
        default: ;
      endcase
    end
    return i;
  endfunction

  function automatic step_t mk(input ctl_t c, input logic mr, input logic z);
    step_t s;
    s.c = c; s.mr = mr; s.z = z;
    return s;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expand one instruction into its expected per-cycle control trace,
  // with nif / nmem memory wait cycles in fetch / data access.
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int nif, input int nmem);
    info_t d;
    ctl_t  c;
    d = decode(op, fn);
    steps.delete();
    for (int k = 0; k < nif; k++) begin
      c = '0; c.st = 3'd1; c.mrd = 1'b1;
      steps.push_back(mk(c, 1'b0, rb()));
    end
    c = '0; c.st = 3'd1; c.mrd = 1'b1; c.irw = 1'b1; c.pcw = 1'b1;
    steps.push_back(mk(c, 1'b1, rb()));

    c = '0; c.st = 3'd2; c.ext = d.ext;
    case (d.kind)
      K_J:    begin c.pcw = 1'b1; c.npc = 2'b10; c.ret = 1'b1; end
      K_JAL:  begin c.pcw = 1'b1; c.npc = 2'b10; c.rw = 1'b1; c.gsel = 2'b10;
                    c.wdsel = 2'b10; c.ret = 1'b1; end
      K_JR:   begin c.pcw = 1'b1; c.npc = 2'b11; c.ret = 1'b1; end
      K_JALR: begin c.pcw = 1'b1; c.npc = 2'b11; c.rw = 1'b1; c.gsel = 2'b10;
                    c.wdsel = 2'b10; c.ret = 1'b1; end
      K_ILL:  c.ill = 1'b1;
      default: ;
    endcase
    steps.push_back(mk(c, rb(), rb()));
    if (d.kind inside {K_J, K_JAL, K_JR, K_JALR, K_ILL}) return;

    c = '0; c.st = 3'd3; c.aluop = d.alu; c.ext = d.ext; c.asel = d.shift;
    c.asrc = (d.kind inside {K_IALU, K_LW, K_SW});
    if (d.kind inside {K_BEQ, K_BNE}) begin
      c.npc = 2'b01;
      c.pcw = (d.kind == K_BEQ) ? z : ~z;
      c.ret = 1'b1;
      steps.push_back(mk(c, rb(), z));
      return;
    end
    steps.push_back(mk(c, rb(), rb()));

    if (d.kind inside {K_LW, K_SW}) begin
      c = '0; c.st = 3'd4; c.iord = 1'b1; c.aluop = d.alu;
      c.mrd = (d.kind == K_LW);
      c.mwr = (d.kind == K_SW);
      for (int k = 0; k < nmem; k++) steps.push_back(mk(c, 1'b0, rb()));
      c.ret = (d.kind == K_SW);
      steps.push_back(mk(c, 1'b1, rb()));
      if (d.kind == K_SW) return;
    end

    c = '0; c.st = 3'd5; c.rw = 1'b1; c.ret = 1'b1; c.aluop = d.alu;
    c.gsel  = (d.kind inside {K_LW, K_IALU}) ? 2'b01 : 2'b00;
    c.wdsel = (d.kind == K_LW) ? 2'b01 : 2'b00;
    steps.push_back(mk(c, rb(), rb()));
  endtask

  task automatic check(input ctl_t exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, compare mid-cycle, advance to just after the edge.
  task automatic apply(input step_t s, input string tag);
    mem_ready = s.mr;
    Zero      = s.z;
    #1;
    check(s.c, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int nif, input int nmem, input string name);
    Op = op;
    Funct = fn;
    build(op, fn, z, nif, nmem);
    foreach (steps[i]) apply(steps[i], $sformatf("%s cyc%0d", name, i));
  endtask

  logic [11:0] legal [24] = '{
    {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23},
    {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h27}, {6'h00, 6'h2a},
    {6'h00, 6'h2b}, {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h08},
    {6'h00, 6'h09}, {6'h08, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00},
    {6'h0a, 6'h00}, {6'h0f, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00},
    {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}
  };

  initial begin
    ctl_t  zc;
    ctl_t  c;
    step_t idle;
    logic [11:0] pick;
    zc = '0;
    idle = mk(zc, 1'b1, 1'b0);
    rstn = 1'b0; Op = 6'h00; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b1;

    // Reset held: everything idle.
    repeat (3) begin
      @(posedge clk);
      #1;
      check(zc, "reset hold");
    end
    rstn = 1'b1;
    apply(idle, "post-reset idle");

    // Directed cases
    run(6'h00, 6'h20, 1'b0, 0, 0, "add");
    run(6'h23, 6'h00, 1'b0, 0, 2, "lw wait2");
    run(6'h04, 6'h00, 1'b1, 0, 0, "beq z1");
    run(6'h05, 6'h00, 1'b1, 0, 0, "bne z1");
    run(6'h03, 6'h00, 1'b0, 0, 0, "jal");
    run(6'h3f, 6'h00, 1'b0, 0, 0, "illegal op3f");
    run(6'h22, 6'h00, 1'b0, 0, 0, "near-miss lw");
    run(6'h00, 6'h28, 1'b0, 0, 0, "bad funct");
    run(6'h00, 6'h09, 1'b0, 2, 0, "jalr ifwait");
    run(6'h2b, 6'h00, 1'b0, 1, 1, "sw waits");
    run(6'h00, 6'h00, 1'b0, 0, 0, "sll");
    run(6'h0f, 6'h00, 1'b0, 0, 0, "lui");

    // Reset asserted mid-MEM of a store.
    Op = 6'h2b; Funct = 6'h00;
    build(6'h2b, 6'h00, 1'b0, 0, 3);
    for (int i = 0; i < 3; i++) apply(steps[i], $sformatf("sw pre-reset cyc%0d", i));
    mem_ready = 1'b0;
    #1;
    check(steps[3].c, "sw mem writing");
    rstn = 1'b0;
    #1;
    check(zc, "async reset drop");
    repeat (3) begin
      @(posedge clk);
      #1;
      check(zc, "reset mid sw");
    end
    rstn = 1'b1;
    apply(idle, "idle after mid reset");
    c = '0; c.st = 3'd1; c.mrd = 1'b1;
    mem_ready = 1'b0;
    #1;
    check(c, "fetch after mid reset");
    @(posedge clk);
    #1;
    // Finish that fetch (still in IF), then continue with random traffic.
    c.irw = 1'b1; c.pcw = 1'b1;
    Op = 6'h02; Funct = 6'h00;
    apply(mk(c, 1'b1, 1'b0), "fetch complete");
    c = '0; c.st = 3'd2; c.pcw = 1'b1; c.npc = 2'b10; c.ret = 1'b1;
    apply(mk(c, 1'b0, 1'b1), "j after reset");

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) pick = 12'($urandom);
      else                           pick = legal[$urandom_range(0, 23)];
      run(pick[11:6], pick[5:0], rb(), $urandom_range(0, 3), $urandom_range(0, 3),
          $sformatf("rnd%0d op%h fn%h", n, pick[11:6], pick[5:0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
